sort_checker: RTL and testbench

Hardware result checker for the sort datapath: on `start`, it reads `arr_size` words from memory over the read-address/read-data channels and verifies they are in non-decreasing order. It connects to the same memory read port that `sort_circuit` uses and runs after `sort_circuit` asserts `done`. It reports pass/fail, the first offending index and any bus error, so benches and silicon self-test check results without a software model.

---
 rtl/sort_pkg.sv | 19 +
 rtl/sort_checker.sv | 174 +++++++++++++++++
 tb/tb_sort_checker.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sort datapath: FSM state encoding, read-response codes
// and default widths. Used by sort_checker and by the memory model.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int RESP_OK  = 0;
  localparam int RESP_ERR = 1;

  localparam int ADDR_WDTH_DEF = 4;
  localparam int DATA_WDTH_DEF = 32;
  localparam int RESP_WDTH_DEF = 1;

endpackage

// File: rtl/sort_checker.sv
// Reads arr_size words from the memory read port and checks non-decreasing order.
// Define SORT_CHECKER_SIGNED_EN to compare words as two's-complement signed values.
module sort_checker
  import sort_pkg::*;
#(
  parameter int ADDR_WDTH = ADDR_WDTH_DEF,
  parameter int DATA_WDTH = DATA_WDTH_DEF,
  parameter int RESP_WDTH = RESP_WDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_WDTH:0]   arr_size,
  input  logic                 start,
  output logic                 done,
  output logic                 pass,
  output logic                 err,
  output logic [ADDR_WDTH-1:0] bad_index,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp
);

  state_e               state_q, state_d;
  logic [ADDR_WDTH:0]   index_q, index_d;
  logic [ADDR_WDTH:0]   size_q, size_d;
  logic [DATA_WDTH-1:0] prev_q, prev_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 err_q, err_d;
  logic [ADDR_WDTH-1:0] bad_index_q, bad_index_d;
  logic                 ar_valid_q, ar_valid_d;
  logic [ADDR_WDTH-1:0] ar_address_q, ar_address_d;
  logic                 r_ready_q, r_ready_d;

  logic                 size_illegal;
  logic                 word_less;
  logic [ADDR_WDTH:0]   index_next;

  // Anything above 2^ADDR_WDTH has the top bit set plus at least one lower bit.
  assign size_illegal = arr_size[ADDR_WDTH] && (|arr_size[ADDR_WDTH-1:0]);
  assign index_next   = index_q + 1'b1;

`ifdef SORT_CHECKER_SIGNED_EN
  assign word_less = $signed(r_data) < $signed(prev_q);
`else
  assign word_less = r_data < prev_q;
`endif

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    size_d       = size_q;
    prev_d       = prev_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_d        = err_q;
    bad_index_d  = bad_index_q;
    ar_valid_d   = ar_valid_q;
    ar_address_d = ar_address_q;
    r_ready_d    = r_ready_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          size_d      = arr_size;
          index_d     = '0;
          pass_d      = 1'b0;
          err_d       = 1'b0;
          bad_index_d = '0;
          if (size_illegal) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (arr_size == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d      = ADDR;
            ar_valid_d   = 1'b1;
            ar_address_d = '0;
          end
        end
      end

      ADDR: begin
        if (ar_ready) begin
          state_d    = DATA;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end

      DATA: begin
        if (r_valid) begin
          r_ready_d = 1'b0;
          if (r_resp != RESP_WDTH'(RESP_OK)) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if ((index_q != '0) && word_less) begin
            state_d     = DONE;
            done_d      = 1'b1;
            bad_index_d = index_q[ADDR_WDTH-1:0];
          end else if (index_q == size_q - 1'b1) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d      = ADDR;
            prev_d       = r_data;
            index_d      = index_next;
            ar_valid_d   = 1'b1;
            ar_address_d = index_next[ADDR_WDTH-1:0];
          end
        end
      end

      DONE: begin
        // Wait for start to drop so a held request does not re-run the check.
        if (!start) begin
          state_d     = IDLE;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = 1'b0;
          bad_index_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      index_q      <= '0;
      size_q       <= '0;
      prev_q       <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= 1'b0;
      bad_index_q  <= '0;
      ar_valid_q   <= 1'b0;
      ar_address_q <= '0;
      r_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      size_q       <= size_d;
      prev_q       <= prev_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      bad_index_q  <= bad_index_d;
      ar_valid_q   <= ar_valid_d;
      ar_address_q <= ar_address_d;
      r_ready_q    <= r_ready_d;
    end
  end

  assign done       = done_q;
  assign pass       = pass_q;
  assign err        = err_q;
  assign bad_index  = bad_index_q;
  assign ar_valid   = ar_valid_q;
  assign ar_address = ar_address_q;
  assign r_ready    = r_ready_q;

endmodule

// File: tb/tb_sort_checker.sv
// Self-checking bench for sort_checker: directed cases plus randomized arrays
// checked against a plain-loop ordering model.
module tb_sort_checker;
  import sort_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RW = 1;
  localparam int MAXN = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   arr_size;
  logic          start;
  logic          done, pass, err;
  logic [AW-1:0] bad_index;
  logic          ar_valid, ar_ready;
  logic [AW-1:0] ar_address;
  logic          r_valid, r_ready;
  logic [DW-1:0] r_data;
  logic [RW-1:0] r_resp;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem [0:MAXN-1];
  logic          always_error = 1'b0;
  int            ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  logic          rnd_bit = 1'b0;
  logic [AW-1:0] addr_log [$];

  always #5 clk = ~clk;

  sort_checker #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) dut (
    .clk(clk), .rst(rst), .arr_size(arr_size), .start(start),
    .done(done), .pass(pass), .err(err), .bad_index(bad_index),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
  );

  assign ar_ready = (ready_mode == 0) || ((ready_mode == 1) && rnd_bit);

  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

  // Zero-wait memory responder: one response the cycle after an address handshake.
  always @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= '0;
    end else begin
      if (r_valid && r_ready) r_valid <= 1'b0;
      if (ar_valid && ar_ready) begin
        r_valid <= 1'b1;
        r_data  <= mem[ar_address];
        r_resp  <= always_error ? RW'(RESP_ERR) : RW'(RESP_OK);
        addr_log.push_back(ar_address);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit less_than(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef SORT_CHECKER_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Reference: scan the array in order and stop at the first problem.
  task automatic model(input int size, output bit e_pass, output bit e_err,
                       output int e_bad, output int e_reads);
    e_pass = 0; e_err = 0; e_bad = 0; e_reads = 0;
    if (size > MAXN) begin
      e_err = 1;
      return;
    end
    for (int i = 0; i < size; i++) begin
      e_reads = i + 1;
      if (always_error) begin
        e_err = 1;
        return;
      end
      if (i > 0 && less_than(mem[i], mem[i-1])) begin
        e_bad = i;
        return;
      end
    end
    e_pass = 1;
  endtask

  task automatic run_check(input string tag, input int size, input int hold);
    bit e_pass, e_err;
    int e_bad, e_reads, cycles, nlog;
    model(size, e_pass, e_err, e_bad, e_reads);
    addr_log.delete();
    @(negedge clk);
    arr_size = (AW+1)'(size);
    start = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (ready_mode != 2) chk({tag, ".exclusive"}, 64'(ar_valid & r_ready), 64'd0);
    end while (!done && cycles < 400);
    chk({tag, ".done"}, 64'(done), 64'd1);
    if (ready_mode == 0)
      chk({tag, ".latency"}, 64'(cycles), 64'((e_reads == 0) ? 1 : 2 * e_reads + 1));
    chk({tag, ".pass"}, 64'(pass), 64'(e_pass));
    chk({tag, ".err"}, 64'(err), 64'(e_err));
    chk({tag, ".bad_index"}, 64'(bad_index), 64'(e_bad));
    nlog = addr_log.size();
    chk({tag, ".reads"}, 64'(nlog), 64'(e_reads));
    for (int i = 0; i < nlog && i < e_reads; i++)
      chk({tag, ".addr"}, 64'(addr_log[i]), 64'(i));
    $display("txn %s size=%0d reads=%0d pass=%0b err=%0b bad=%0d cycles=%0d",
             tag, size, nlog, pass, err, bad_index, cycles);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({tag, ".held_done"}, 64'(done), 64'd1);
      chk({tag, ".held_noreads"}, 64'(addr_log.size()), 64'(nlog));
    end
    start = 1'b0;
    @(negedge clk);
    chk({tag, ".idle"}, 64'(done), 64'd0);
  endtask

  task automatic fill_sorted(input int n);
    logic [DW-1:0] v;
    v = DW'($urandom_range(0, 1000));
    for (int i = 0; i < MAXN; i++) begin
      mem[i] = v;
      v = v + DW'($urandom_range(0, 50));
    end
  endtask

  initial begin
    int cycles, sz;
    logic [AW-1:0] a0;
    rst = 1'b1; start = 1'b0; arr_size = '0;
    for (int i = 0; i < MAXN; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.pass", 64'(pass), 64'd0);
    chk("reset.err", 64'(err), 64'd0);
    chk("reset.bad_index", 64'(bad_index), 64'd0);
    chk("reset.ar_valid", 64'(ar_valid), 64'd0);
    chk("reset.ar_address", 64'(ar_address), 64'd0);
    chk("reset.r_ready", 64'(r_ready), 64'd0);
    rst = 1'b0;

    mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
    run_check("sorted4", 4, 0);
    mem[0] = 1; mem[1] = 3; mem[2] = 2; mem[3] = 4;
    run_check("unsorted4", 4, 0);
    always_error = 1'b1;
    run_check("buserr", 4, 0);
    always_error = 1'b0;
    run_check("size0", 0, 0);
    run_check("size17", 17, 0);
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h0;
    run_check("signcase", 2, 0);
    fill_sorted(MAXN);
    run_check("size16", 16, 0);
    mem[15] = 0;
    run_check("lastbad16", 16, 0);
    fill_sorted(3);
    run_check("heldstart", 3, 4);

    // Address channel stalled for three cycles: request must not move.
    ready_mode = 2;
    @(negedge clk);
    arr_size = 5'd2;
    start = 1'b1;
    @(negedge clk);
    a0 = ar_address;
    chk("stall.ar_valid", 64'(ar_valid), 64'd1);
    chk("stall.addr0", 64'(a0), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("stall.hold_valid", 64'(ar_valid), 64'd1);
      chk("stall.hold_addr", 64'(ar_address), 64'(a0));
    end
    ready_mode = 0;
    cycles = 0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    chk("stall.done", 64'(done), 64'd1);
    chk("stall.pass", 64'(pass), 64'd1);
    $display("txn stall size=2 pass=%0b", pass);
    start = 1'b0;
    @(negedge clk);

    // Reset while waiting for read data.
    arr_size = 5'd4;
    start = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!r_ready && cycles < 50);
    chk("rstmid.in_data", 64'(r_ready), 64'd1);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("rstmid.done", 64'(done), 64'd0);
    chk("rstmid.pass", 64'(pass), 64'd0);
    chk("rstmid.err", 64'(err), 64'd0);
    chk("rstmid.bad_index", 64'(bad_index), 64'd0);
    chk("rstmid.ar_valid", 64'(ar_valid), 64'd0);
    chk("rstmid.ar_address", 64'(ar_address), 64'd0);
    chk("rstmid.r_ready", 64'(r_ready), 64'd0);
    $display("txn rstmid outputs cleared");
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 30; t++) begin
      sz = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
      fill_sorted(MAXN);
      if ($urandom_range(0, 1) == 1) mem[$urandom_range(0, 15)] = $urandom;
      always_error = ($urandom_range(0, 7) == 0);
      ready_mode = $urandom_range(0, 1);
      run_check($sformatf("rand%0d", t), sz, 0);
    end
    always_error = 1'b0;
    ready_mode = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
